conv_stream_ctrl: RTL

//  Frame sequencer for the 3x3 line-buffer feeder and systolic convolution array.
//  - Accepts a raster pixel stream over a valid/ready handshake.
//  - Drives feed_en, which advances the feeder and array by one step.
//  - Tracks x/y position and tags each complete KxK window.
//  - Delays tags by the fixed datapath latency; flags valid array outputs with coordinates.
//  - Flushes the pipeline at end of frame and pulses done.

---
 rtl/conv_stream_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for the KxK line-buffer feeder and systolic array.
// Steps the datapath on pixel accept and drain cycles, and tags window results.
module conv_stream_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int K        = 3,
  parameter int PIPE_LAT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic                       feed_en,
  output logic                       res_valid,
  output logic [$clog2(IMG_W)-1:0]   res_x,
  output logic [$clog2(IMG_H)-1:0]   res_y,
  output logic                       busy,
  output logic                       done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int NS = PIPE_LAT - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_K    = XW'(K - 1);
  localparam logic [YW-1:0] Y_K    = YW'(K - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [DW-1:0]   drain_r;
  logic [NS-1:0]   tag_v_r;
  logic [XW-1:0]   tag_x_r [NS];
  logic [YW-1:0]   tag_y_r [NS];
  logic            res_valid_r;
  logic [XW-1:0]   res_x_r;
  logic [YW-1:0]   res_y_r;
  logic            accept_s, last_pix_s, win_s, frame_start_s;

  assign accept_s      = pix_valid & pix_ready;
  assign last_pix_s    = (x_r == X_LAST) && (y_r == Y_LAST);
  assign win_s         = (x_r >= X_K) && (y_r >= Y_K);
  assign frame_start_s = (state_r == ST_IDLE) && start;

  // Handshake and step strobes decoded from the current state
  always_comb begin
    pix_ready = 1'b0;
    feed_en   = 1'b0;
    case (state_r)
      ST_RUN: begin
        pix_ready = 1'b1;
        feed_en   = pix_valid;
      end
      ST_DRAIN: feed_en = 1'b1;
      default: begin
        pix_ready = 1'b0;
        feed_en   = 1'b0;
      end
    endcase
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = start ? ST_RUN : ST_IDLE;
        ST_RUN:   state_s = (accept_s && last_pix_s) ? ST_DRAIN : ST_RUN;
        ST_DRAIN: state_s = (drain_r == D_LAST) ? ST_DONE : ST_DRAIN;
        ST_DONE:  state_s = ST_IDLE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Raster position, advanced on accepted pixels only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (abort || frame_start_s) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (accept_s) begin
      if (x_r == X_LAST) begin
        x_r <= {XW{1'b0}};
        y_r <= (y_r == Y_LAST) ? {YW{1'b0}} : y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Drain cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                drain_r <= {DW{1'b0}};
    else if (abort || state_r != ST_DRAIN)  drain_r <= {DW{1'b0}};
    else                                    drain_r <= drain_r + DW'(1);
  end

  // Tag pipe mirrors datapath latency; drain steps push in empty tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r <= {NS{1'b0}};
      for (int i = 0; i < NS; i++) begin
        tag_x_r[i] <= {XW{1'b0}};
        tag_y_r[i] <= {YW{1'b0}};
      end
    end else if (abort) begin
      tag_v_r <= {NS{1'b0}};
    end else if (feed_en) begin
      for (int i = NS - 1; i > 0; i--) begin
        tag_v_r[i] <= tag_v_r[i-1];
        tag_x_r[i] <= tag_x_r[i-1];
        tag_y_r[i] <= tag_y_r[i-1];
      end
      tag_v_r[0] <= accept_s & win_s;
      tag_x_r[0] <= x_r - X_K;
      tag_y_r[0] <= y_r - Y_K;
    end
  end

  // Registered result flag and coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_x_r     <= {XW{1'b0}};
      res_y_r     <= {YW{1'b0}};
    end else begin
      res_valid_r <= ~abort & feed_en & tag_v_r[NS-1];
      if (feed_en && tag_v_r[NS-1]) begin
        res_x_r <= tag_x_r[NS-1];
        res_y_r <= tag_y_r[NS-1];
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_x     = res_x_r;
  assign res_y     = res_y_r;
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);

endmodule
